// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/memory types -- word_t, ramstate_t, arbiter state, block size default
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
   typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} arb_state_t;
   localparam int BLOCK_WORDS_DEF = 2;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after ptr
//  req   in  NCPU  request vector
//  ptr   in  IW    index that gets first look
//  valid out 1     any request set
//  idx   out IW    chosen index
module rr_picker #(
   parameter int NCPU = 2,
   localparam int IW = NCPU > 1 ? $clog2(NCPU) : 1
) (
   input  logic [NCPU-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            valid,
   output logic [IW-1:0]   idx
);
   // Walk from farthest to nearest so the nearest hit from ptr is the last write.
   always_comb begin
      valid = |req;
      idx = '0;
      for (int k = NCPU - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % NCPU]) idx = IW'((int'(ptr) + k) % NCPU);
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between per-core icache/dcache, data first, round-robin cores
//  CLK, nRST              clock, async active-low reset
//  iREN/iaddr -> iwait/iload         icache side, per core
//  dREN/dWEN/daddr/dstore -> dwait/dload  dcache side, per core
//  ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate  RAM side
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NCPU = 2,
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [NCPU-1:0]     iREN,
   input  logic [NCPU*32-1:0]  iaddr,
   output logic [NCPU-1:0]     iwait,
   output logic [NCPU*32-1:0]  iload,
   input  logic [NCPU-1:0]     dREN,
   input  logic [NCPU-1:0]     dWEN,
   input  logic [NCPU*32-1:0]  daddr,
   input  logic [NCPU*32-1:0]  dstore,
   output logic [NCPU-1:0]     dwait,
   output logic [NCPU*32-1:0]  dload,
   output logic                ramREN,
   output logic                ramWEN,
   output logic [31:0]         ramaddr,
   output logic [31:0]         ramstore,
   input  logic [31:0]         ramload,
   input  logic [1:0]          ramstate
);
   localparam int IW = NCPU > 1 ? $clog2(NCPU) : 1;
   localparam int WW = $clog2(BLOCK_WORDS) + 1;

   arb_state_t      state, next;
   logic [IW-1:0]   gsel, gsel_n, rr_ptr, rr_ptr_n;
   logic [WW-1:0]   wcnt, wcnt_n;
   logic [NCPU-1:0] dreq;
   logic            d_valid, i_valid, access, release_g;
   logic [IW-1:0]   d_idx, i_idx;

   assign dreq = dREN | dWEN;
   assign access = ramstate_t'(ramstate) == ACCESS;

   rr_picker #(.NCPU(NCPU)) u_dpick (.req(dreq), .ptr(rr_ptr), .valid(d_valid), .idx(d_idx));
   rr_picker #(.NCPU(NCPU)) u_ipick (.req(iREN), .ptr(rr_ptr), .valid(i_valid), .idx(i_idx));

   always_ff @(posedge CLK, negedge nRST)
      if (!nRST) begin
         state <= IDLE;
         gsel <= '0;
         wcnt <= '0;
         rr_ptr <= '0;
      end else begin
         state <= next;
         gsel <= gsel_n;
         wcnt <= wcnt_n;
         rr_ptr <= rr_ptr_n;
      end

   // Outputs decode from the async-reset state, so reset drops the RAM enables immediately.
   always_comb begin
      next = state;
      gsel_n = gsel;
      wcnt_n = wcnt;
      rr_ptr_n = rr_ptr;
      release_g = 1'b0;
      iwait = '1;
      dwait = '1;
      iload = '0;
      dload = '0;
      ramREN = 1'b0;
      ramWEN = 1'b0;
      ramaddr = '0;
      ramstore = '0;
      case (state)
         IDLE: begin
            next = d_valid ? GRANT_D : i_valid ? GRANT_I : IDLE;
            gsel_n = d_valid ? d_idx : i_valid ? i_idx : gsel;
         end
         GRANT_D: begin
            ramaddr = daddr[32*int'(gsel) +: 32];
            ramstore = dstore[32*int'(gsel) +: 32];
            ramWEN = dWEN[gsel];
            ramREN = dREN[gsel] & ~dWEN[gsel];
            dwait[gsel] = ~access;
            dload[32*int'(gsel) +: 32] = ramload;
            release_g = ~dreq[gsel] | (access && wcnt == WW'(BLOCK_WORDS - 1));
            wcnt_n = access ? wcnt + 1'b1 : wcnt;
         end
         GRANT_I: begin
            ramREN = 1'b1;
            ramaddr = iaddr[32*int'(gsel) +: 32];
            iwait[gsel] = ~access;
            iload[32*int'(gsel) +: 32] = ramload;
            release_g = ~iREN[gsel] | access;
         end
         default: next = IDLE;
      endcase
      if (release_g) begin
         next = IDLE;
         wcnt_n = '0;
         rr_ptr_n = IW'((int'(gsel) + 1) % NCPU);
      end
   end
endmodule
